ifu: RTL and testbench



---
 rtl/ifu_if.sv | 26 ++
 rtl/ifu.sv | 101 ++++++++++
 tb/tb_ifu.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect, decode output.
interface ifu_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one fetch in flight and
// hands each word to decode; redirects squash whatever fetch is outstanding.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifu_if.master       bus,
    output logic [31:0] fetch_cnt
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FLUSH
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   out_instr_q;
    logic [XLEN-1:0]   out_pc_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   fetch_cnt_q;
    logic [XLEN-1:0]   redir_pc;

    // Redirect targets are forced to word alignment.
    assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_instr      = out_instr_q;
    assign bus.out_pc         = out_pc_q;
    assign fetch_cnt          = fetch_cnt_q;

    // Redirect wins over every other event except in BOOT; stray responses
    // outside WAIT/FLUSH fall through the case arms untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            out_instr_q <= '0;
            out_pc_q    <= RESET_PC;
            out_valid_q <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.redirect_valid) begin
                        pc_q        <= redir_pc;
                        out_valid_q <= 1'b0;
                        state_q     <= bus.imem_req_ready ? ST_FLUSH : ST_REQ;
                    end else if (bus.imem_req_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.redirect_valid) begin
                        pc_q        <= redir_pc;
                        out_valid_q <= 1'b0;
                        state_q     <= bus.imem_rsp_valid ? ST_REQ : ST_FLUSH;
                    end else if (bus.imem_rsp_valid) begin
                        out_instr_q <= bus.imem_rsp_data;
                        out_pc_q    <= pc_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect_valid) begin
                        pc_q        <= redir_pc;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_REQ;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= XLEN'(pc_q + XLEN'(4));
                        fetch_cnt_q <= XLEN'(fetch_cnt_q + XLEN'(1));
                        state_q     <= ST_REQ;
                    end
                end
                ST_FLUSH: begin
                    if (bus.redirect_valid) begin
                        pc_q        <= redir_pc;
                        out_valid_q <= 1'b0;
                    end else if (bus.imem_rsp_valid) begin
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: stimulus pushes expected fetch addresses and
// decode handoffs; a monitor branch pops and compares as the DUT presents them.
module tb_ifu;
    logic        clk;
    logic        rst;
    logic [31:0] fetch_cnt;

    ifu_if bus ();

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Memory responder: auto mode answers one cycle after acceptance with
    // {addr[31:2],2'b11}; manual mode lets the sequence inject responses.
    logic        auto_en, auto_v, man_v, acc_pend;
    logic [31:0] auto_d, man_d, acc_addr;

    assign bus.imem_rsp_valid = auto_v | man_v;
    assign bus.imem_rsp_data  = auto_v ? auto_d : man_d;

    always @(negedge clk) begin
        acc_pend = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_req_addr;
    end

    always begin
        @(posedge clk);
        #1;
        auto_v = auto_en && acc_pend;
        auto_d = {acc_addr[31:2], 2'b11};
    end

    int          n_chk;
    int          n_fail;
    logic [31:0] exp_req[$];
    logic [63:0] exp_out[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
                if (exp_req.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %08h expected none", bus.imem_req_addr);
                end else begin
                    chk("req_addr", bus.imem_req_addr, exp_req.pop_front());
                end
            end
            // A redirect in the same cycle cancels the decode handshake.
            if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
                if (exp_out.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got pc %08h instr %08h expected none",
                             bus.out_pc, bus.out_instr);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_pc", bus.out_pc, e[63:32]);
                    chk("out_instr", bus.out_instr, e[31:0]);
                end
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, 32'h8000_0000);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_instr"}, bus.out_instr, 32'h0);
        chk({tag, "_out_pc"}, bus.out_pc, 32'h8000_0000);
        chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    endtask

    initial begin
        int n;
        clk = 1'b0;
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        auto_en = 1'b0;
        auto_v  = 1'b0;
        auto_d  = '0;
        man_v   = 1'b0;
        man_d   = '0;
        acc_pend = 1'b0;
        acc_addr = '0;
        n_chk  = 0;
        n_fail = 0;
        fork
            monitor();
        join_none

        tick();
        tick();
        chk_reset_vals("rst");

        // Free-running fetch of three words
        exp_req.push_back(32'h8000_0000);
        exp_req.push_back(32'h8000_0004);
        exp_req.push_back(32'h8000_0008);
        exp_out.push_back({32'h8000_0000, 32'h8000_0003});
        exp_out.push_back({32'h8000_0004, 32'h8000_0007});
        exp_out.push_back({32'h8000_0008, 32'h8000_000B});
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        auto_en            = 1'b1;
        rst = 1'b0;
        tick();
        chk("c1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        tick();
        chk("c2_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("c3_out_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("c4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("c4_fetch_cnt", fetch_cnt, 32'd1);
        n = 0;
        while (fetch_cnt != 32'd3 && n < 30) begin
            tick();
            n++;
        end
        bus.imem_req_ready = 1'b0;
        auto_en = 1'b0;
        chk("run_fetch_cnt", fetch_cnt, 32'd3);
        chk("run_next_addr", bus.imem_req_addr, 32'h8000_000C);

        // Decode backpressure
        bus.out_ready = 1'b0;
        auto_en = 1'b1;
        exp_req.push_back(32'h8000_000C);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_instr", bus.out_instr, 32'h8000_000F);
            chk("bp_out_pc", bus.out_pc, 32'h8000_000C);
            chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
            tick();
        end
        exp_out.push_back({32'h8000_000C, 32'h8000_000F});
        bus.out_ready = 1'b1;
        tick();
        auto_en = 1'b0;
        chk("bp_next_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("bp_next_addr", bus.imem_req_addr, 32'h8000_0010);
        chk("bp_fetch_cnt", fetch_cnt, 32'd4);

        // Redirect while waiting for a response; late response goes to FLUSH
        exp_req.push_back(32'h8000_0010);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0101;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rw_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        man_v = 1'b1;
        man_d = 32'hDEAD_BEEF;
        tick();
        man_v = 1'b0;
        chk("rw_req_valid2", 32'(bus.imem_req_valid), 32'd1);
        chk("rw_addr", bus.imem_req_addr, 32'h8000_0100);
        chk("rw_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rw_fetch_cnt", fetch_cnt, 32'd4);

        // Redirect coinciding with acceptance in REQ
        exp_req.push_back(32'h8000_0100);
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rr_flush_req", 32'(bus.imem_req_valid), 32'd0);
        man_v = 1'b1;
        man_d = 32'h0BAD_0013;
        tick();
        man_v = 1'b0;
        chk("rr_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("rr_addr", bus.imem_req_addr, 32'h8000_0200);
        chk("rr_out_valid", 32'(bus.out_valid), 32'd0);

        // Redirect coinciding with the response in WAIT
        exp_req.push_back(32'h8000_0200);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0300;
        man_v = 1'b1;
        man_d = 32'hCAFE_0013;
        tick();
        bus.redirect_valid = 1'b0;
        man_v = 1'b0;
        chk("wr_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("wr_addr", bus.imem_req_addr, 32'h8000_0300);
        chk("wr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("wr_fetch_cnt", fetch_cnt, 32'd4);

        // Redirect coinciding with the decode handshake in HOLD
        bus.out_ready = 1'b0;
        exp_req.push_back(32'h8000_0300);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        man_v = 1'b1;
        man_d = 32'h1111_1113;
        tick();
        man_v = 1'b0;
        chk("hr_out_valid", 32'(bus.out_valid), 32'd1);
        chk("hr_out_pc", bus.out_pc, 32'h8000_0300);
        chk("hr_out_instr", bus.out_instr, 32'h1111_1113);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("hr_fetch_cnt", fetch_cnt, 32'd4);
        chk("hr_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        chk("hr_out_valid2", 32'(bus.out_valid), 32'd0);

        // Fetch at the top of the address space; PC wraps to zero
        exp_req.push_back(32'hFFFF_FFFC);
        exp_out.push_back({32'hFFFF_FFFC, 32'h2222_2223});
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        man_v = 1'b1;
        man_d = 32'h2222_2223;
        tick();
        man_v = 1'b0;
        tick();
        chk("wrap_addr", bus.imem_req_addr, 32'h0000_0000);
        chk("wrap_fetch_cnt", fetch_cnt, 32'd5);

        // Asynchronous reset while a fetch is outstanding
        exp_req.push_back(32'h0000_0000);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        tick();
        rst = 1'b0;
        man_v = 1'b1;
        man_d = 32'h3333_3333;
        tick();
        tick();
        man_v = 1'b0;
        chk("stray_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("stray_addr", bus.imem_req_addr, 32'h8000_0000);
        chk("stray_out_valid", 32'(bus.out_valid), 32'd0);
        chk("stray_fetch_cnt", fetch_cnt, 32'd0);

        exp_req.push_back(32'h8000_0000);
        exp_out.push_back({32'h8000_0000, 32'h8000_0003});
        auto_en = 1'b1;
        bus.imem_req_ready = 1'b1;
        n = 0;
        while (fetch_cnt != 32'd1 && n < 20) begin
            tick();
            n++;
        end
        bus.imem_req_ready = 1'b0;
        chk("restart_fetch_cnt", fetch_cnt, 32'd1);
        chk("restart_addr", bus.imem_req_addr, 32'h8000_0004);
        tick();
        tick();
        chk("exp_req_left", 32'(exp_req.size()), 32'd0);
        chk("exp_out_left", 32'(exp_out.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
